// File: rtl/bch_error_collect_if.sv
// Chien-stream / controller bus of the BCH error-location collector.
// The controller side (and the bench) use master; the collector uses slave.
interface bch_error_collect_if #(
    parameter int T  = 3,
    parameter int PW = 10,
    parameter int CW = 3
);
    logic              start;
    logic [CW-1:0]     err_deg;
    logic              valid;
    logic              first;
    logic              last;
    logic              err;
    logic              accepted;
    logic              busy;
    logic              done;
    logic [CW-1:0]     err_count;
    logic [T*PW-1:0]   locs;
    logic [T-1:0]      loc_mask;
    logic              fail;

    modport master (
        output start, err_deg, valid, first, last, err,
        input  accepted, busy, done, err_count, locs, loc_mask, fail
    );

    modport slave (
        input  start, err_deg, valid, first, last, err,
        output accepted, busy, done, err_count, locs, loc_mask, fail
    );
endinterface

// File: rtl/bch_error_collect.sv
// Collects flagged Chien-search positions for one codeword and checks the
// error count against the locator degree, flagging uncorrectable/malformed words.
module bch_error_collect #(
    parameter int N  = 1023,
    parameter int T  = 3,
    parameter int PW = $clog2(N),
    parameter int CW = $clog2(T + 2)
) (
    input logic                clk,
    input logic                rst_n,
    bch_error_collect_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, COLLECT, DONE} state_t;

    localparam logic [CW-1:0] T_C      = CW'(T);
    localparam logic [CW-1:0] T_SAT    = CW'(T + 1);
    localparam logic [PW-1:0] LAST_POS = PW'(N - 1);

    state_t          state, state_nxt;
    logic            beat;
    logic [CW-1:0]   exp_cnt;
    logic [PW-1:0]   pos;
    logic            proto_err;
    logic            pos_ovf;
    logic [CW-1:0]   cnt_q;
    logic [T-1:0]    mask_q;
    logic [T*PW-1:0] locs_q;
    logic            fail_q;
    logic            done_q;

    logic [CW-1:0]   cnt_base, cnt_nxt;
    logic [T-1:0]    mask_base, mask_nxt;
    logic [T*PW-1:0] locs_base, locs_nxt;
    logic [PW-1:0]   pos_base, pos_nxt;
    logic            proto_nxt, ovf_nxt, fail_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // start has priority over any beat in every state.
    always_comb begin
        state_nxt = state;
        beat      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) state_nxt = ARMED;
            end
            ARMED: begin
                if (bus.start) begin
                    state_nxt = ARMED;
                end else if (bus.valid && bus.first) begin
                    beat      = 1'b1;
                    state_nxt = bus.last ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (bus.start) begin
                    state_nxt = ARMED;
                end else if (bus.valid) begin
                    beat = 1'b1;
                    if (bus.last) state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A first beat restarts the word: the beat works on cleared results at pos 0.
    always_comb begin
        cnt_base  = bus.first ? '0 : cnt_q;
        mask_base = bus.first ? '0 : mask_q;
        locs_base = bus.first ? '0 : locs_q;
        pos_base  = bus.first ? '0 : pos;
        cnt_nxt   = cnt_base;
        mask_nxt  = mask_base;
        locs_nxt  = locs_base;
        for (int k = 0; k < T; k++) begin
            if (bus.err && cnt_base == CW'(k)) begin
                mask_nxt[k]           = 1'b1;
                locs_nxt[k*PW +: PW]  = pos_base;
            end
        end
        if (bus.err) cnt_nxt = (cnt_base == T_SAT) ? T_SAT : cnt_base + 1'b1;
        pos_nxt   = (pos_base == LAST_POS) ? LAST_POS : pos_base + 1'b1;
        proto_nxt = proto_err | (state == COLLECT && bus.first);
        // pos saturates, so a beat past N-1 is remembered separately as an overrun.
        ovf_nxt   = (bus.first ? 1'b0 : pos_ovf) | (pos_base == LAST_POS && !bus.last);
        fail_nxt  = (cnt_nxt != exp_cnt) || (cnt_nxt > T_C) ||
                    (pos_base != LAST_POS) || ovf_nxt || proto_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnt   <= '0;
            pos       <= '0;
            proto_err <= 1'b0;
            pos_ovf   <= 1'b0;
            cnt_q     <= '0;
            mask_q    <= '0;
            locs_q    <= '0;
            fail_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                exp_cnt   <= bus.err_deg;
                pos       <= '0;
                proto_err <= 1'b0;
                pos_ovf   <= 1'b0;
                cnt_q     <= '0;
                mask_q    <= '0;
                locs_q    <= '0;
                fail_q    <= 1'b0;
            end else if (beat) begin
                cnt_q     <= cnt_nxt;
                mask_q    <= mask_nxt;
                locs_q    <= locs_nxt;
                pos       <= pos_nxt;
                proto_err <= proto_nxt;
                pos_ovf   <= ovf_nxt;
                if (bus.last) begin
                    done_q <= 1'b1;
                    fail_q <= fail_nxt;
                end
            end
        end
    end

    assign bus.accepted  = (state == ARMED) || (state == COLLECT);
    assign bus.busy      = (state == ARMED) || (state == COLLECT);
    assign bus.done      = done_q;
    assign bus.err_count = cnt_q;
    assign bus.locs      = locs_q;
    assign bus.loc_mask  = mask_q;
    assign bus.fail      = fail_q;
endmodule

// File: tb/tb_bch_error_collect.sv
// Randomized bench for bch_error_collect: codewords are described as an
// error bitmap plus length / restart / abort choices and scored by a list model.
module tb_bch_error_collect;
    localparam int N  = 1023;
    localparam int T  = 3;
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(T + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bch_error_collect_if #(.T(T), .PW(PW), .CW(CW)) bus();
    bch_error_collect #(.N(N), .T(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    bit emap [N+8];

    task automatic chk(input string tag, input logic [63:0] got, input longint want);
        n_chk++;
        if (got !== 64'(want)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit f, input bit l, input bit e);
        bus.valid = v;
        bus.first = f;
        bus.last  = l;
        bus.err   = e;
    endtask

    task automatic clr_map();
        foreach (emap[i]) emap[i] = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acc"},  bus.accepted,  0);
        chk({tag, "_busy"}, bus.busy,      0);
        chk({tag, "_done"}, bus.done,      0);
        chk({tag, "_cnt"},  bus.err_count, 0);
        chk({tag, "_locs"}, bus.locs,      0);
        chk({tag, "_mask"}, bus.loc_mask,  0);
        chk({tag, "_fail"}, bus.fail,      0);
    endtask

    // One codeword of len beats; rf>0 repeats first at that beat, abort_at
    // issues start with that beat, rst_at pulls reset while that beat is driven.
    task automatic run_cw(input int deg, input int len, input int rf, input int abort_at,
                          input int rst_at, input bit gaps, input bit b2b);
        int q[$];
        int early = 0;
        int rf0, n, cnt, nslot;
        logic [T*PW-1:0] el;
        bit ef;

        bus.start = 1'b1;
        bus.err_deg = CW'(deg);
        drive(0, 0, 0, 0);
        step();
        bus.start = 1'b0;
        chk("arm_acc",  bus.accepted, 1);
        chk("arm_busy", bus.busy, 1);
        chk("arm_done", bus.done, 0);
        chk("arm_cnt",  bus.err_count, 0);
        chk("arm_mask", bus.loc_mask, 0);
        chk("arm_fail", bus.fail, 0);

        if (gaps && $urandom_range(1) == 1) begin
            drive(1, 0, 1'($urandom_range(1)), 1);
            step();
        end

        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    drive(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
                    step();
                    if (bus.done) early++;
                end
            end
            drive(1, (i == 0) || (i == rf), i == len - 1, emap[i]);
            if (i == abort_at) begin
                bus.start = 1'b1;
                step();
                bus.start = 1'b0;
                drive(0, 0, 0, 0);
                chk("abort_done", bus.done, 0);
                chk("abort_acc",  bus.accepted, 1);
                chk("abort_cnt",  bus.err_count, 0);
                chk("abort_locs", bus.locs, 0);
                chk("abort_mask", bus.loc_mask, 0);
                chk("abort_early", early, 0);
                return;
            end
            if (i == rst_at) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("rst_mid");
                step();
                rst_n = 1'b1;
                drive(0, 0, 0, 0);
                step();
                chk("rst_idle_busy", bus.busy, 0);
                chk("rst_idle_done", bus.done, 0);
                return;
            end
            step();
            if (i != len - 1 && bus.done) early++;
        end
        drive(0, 0, 0, 0);

        // Model: the word seen is everything from the last first beat onward.
        rf0 = (rf > 0) ? rf : 0;
        for (int i = rf0; i < len; i++)
            if (emap[i]) q.push_back((i - rf0 > N - 1) ? N - 1 : i - rf0);
        n     = q.size();
        cnt   = (n > T) ? T + 1 : n;
        nslot = (n > T) ? T : n;
        el    = '0;
        for (int k = 0; k < nslot; k++) el[k*PW +: PW] = PW'(q[k]);
        ef = (cnt != deg) || (n > T) || (len - rf0 != N) || (rf > 0);

        chk("early_done", early, 0);
        chk("done",       bus.done, 1);
        chk("err_count",  bus.err_count, cnt);
        chk("locs",       bus.locs, longint'(el));
        chk("loc_mask",   bus.loc_mask, (1 << nslot) - 1);
        chk("fail",       bus.fail, ef);
        chk("done_busy",  bus.busy, 0);
        if (!b2b) begin
            step();
            chk("done_pulse", bus.done, 0);
            chk("hold_cnt",   bus.err_count, cnt);
            chk("hold_fail",  bus.fail, ef);
        end
    endtask

    initial begin
        int ne, len, rf, deg;
        bus.start = 1'b0;
        bus.err_deg = '0;
        drive(0, 0, 0, 0);
        #12;
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 1);
            step();
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
        end
        drive(0, 0, 0, 0);

        clr_map(); emap[5] = 1; emap[1000] = 1;
        run_cw(2, N, -1, -1, -1, 0, 0);
        run_cw(3, N, -1, -1, -1, 1, 0);
        clr_map(); for (int i = 0; i < 5; i++) emap[i] = 1;
        run_cw(3, N, -1, -1, -1, 0, 0);
        clr_map(); emap[10] = 1;
        run_cw(1, 501, -1, -1, -1, 0, 0);
        clr_map(); emap[100] = 1; emap[400] = 1;
        run_cw(1, N + 300, 300, -1, -1, 0, 0);
        clr_map(); emap[0] = 1;
        run_cw(1, 1, -1, -1, -1, 0, 0);
        clr_map(); emap[7] = 1;
        run_cw(2, N, -1, 600, -1, 0, 0);
        clr_map(); emap[3] = 1; emap[9] = 1; emap[N-1] = 1;
        run_cw(3, N, -1, -1, -1, 0, 0);
        clr_map(); emap[1] = 1;
        run_cw(1, N, -1, -1, -1, 1, 1);
        clr_map(); emap[2] = 1; emap[50] = 1;
        run_cw(2, N, -1, -1, -1, 1, 0);
        clr_map(); emap[20] = 1;
        run_cw(1, N + 2, -1, -1, -1, 0, 0);

        for (int r = 0; r < 6; r++) begin
            clr_map();
            ne = $urandom_range(5);
            for (int j = 0; j < ne; j++) emap[$urandom_range(N - 1)] = 1;
            case ($urandom_range(5))
                0:       len = $urandom_range(N - 2, 2);
                1:       len = N + 1;
                default: len = N;
            endcase
            rf  = ($urandom_range(4) == 0) ? $urandom_range(len - 1, 1) : -1;
            deg = $urandom_range(4);
            run_cw(deg, len, rf, -1, -1, 1, 1'($urandom_range(1)));
        end

        clr_map(); emap[3] = 1; emap[30] = 1;
        run_cw(2, N, -1, -1, 200, 0, 0);
        clr_map(); emap[500] = 1;
        run_cw(1, N, -1, -1, -1, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
